// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Word width and drain FSM encoding.
package uart_pkg;

  localparam int UART_WORD_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer and transmitter signals of the buffered UART TX front-end.
// slave is the FIFO side; master is the producer/transmitter side.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
);

  logic [UART_WORD_BITS-1:0] wrData;
  logic                      wrEn;
  logic                      flush;
  logic                      full;
  logic                      empty;
  logic [DEPTH_LOG2:0]       count;
  logic                      overflow;
  logic                      busy;
  logic [UART_WORD_BITS-1:0] txIn;
  logic                      txSend;
  logic                      txSendComplete;

  modport slave (
    input  wrData,
    input  wrEn,
    input  flush,
    input  txSendComplete,
    output full,
    output empty,
    output count,
    output overflow,
    output busy,
    output txIn,
    output txSend
  );

  modport master (
    output wrData,
    output wrEn,
    output flush,
    output txSendComplete,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  busy,
    input  txIn,
    input  txSend
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered count/full/empty.
// Writes while full and all traffic during flush are dropped.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DEPTH_LOG2:0]   count_n;

  assign wr_ok   = wr && !full && !flush;
  assign rd_ok   = rd && !empty && !flush;
  assign rd_data = mem[rptr];

  always_comb begin
    count_n = count;
    if (wr_ok && !rd_ok)
      count_n = count + 1'b1;
    else if (rd_ok && !wr_ok)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok)
        rptr <= rptr + 1'b1;
      count <= count_n;
      full  <= (count_n == DEPTH_C);
      empty <= (count_n == '0);
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_ok)
      mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered front-end for the UART transmitter: FIFO plus drain FSM
// driving the txIn/txSend/txSendComplete handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CLKS   = 0
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int GW =
    (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  uart_tx_state_t            state;
  uart_tx_state_t            state_n;
  logic [UART_WORD_BITS-1:0] tx_data;
  logic [UART_WORD_BITS-1:0] tx_data_n;
  logic                      send;
  logic                      send_n;
  logic [GW-1:0]             gap_cnt;
  logic [GW-1:0]             gap_cnt_n;
  logic                      ovf;
  logic                      pop;
  logic [UART_WORD_BITS-1:0] head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [DEPTH_LOG2:0]       fifo_count;

  sync_fifo #(
    .WIDTH      (UART_WORD_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr      (bus.wrEn),
    .wr_data (bus.wrData),
    .rd      (pop),
    .rd_data (head),
    .flush   (bus.flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_n   = state;
    tx_data_n = tx_data;
    send_n    = 1'b0;
    gap_cnt_n = gap_cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        // A flushing queue must not launch its head byte.
        if (!fifo_empty && !bus.flush) begin
          pop       = 1'b1;
          tx_data_n = head;
          send_n    = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: begin
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.txSendComplete) begin
          gap_cnt_n = '0;
          state_n   = (GAP_CLKS > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST)
          state_n = IDLE;
        else
          gap_cnt_n = gap_cnt + 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      tx_data <= '0;
      send    <= 1'b0;
      gap_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      tx_data <= tx_data_n;
      send    <= send_n;
      gap_cnt <= gap_cnt_n;
      ovf     <= bus.wrEn && fifo_full && !bus.flush;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = ovf;
  assign bus.busy     = (state != IDLE) || !fifo_empty;
  assign bus.txIn     = tx_data;
  assign bus.txSend   = send;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one back-to-back instance
// and one with a 5-clock inter-byte gap.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic model_done = 1'b0;
  logic man0_done  = 1'b0;
  logic man5_done  = 1'b0;
  bit   auto0      = 1'b0;
  int   tx_delay   = 1390;

  int sends0 = 0;
  int sends5 = 0;
  int ovf0   = 0;
  int full0  = 0;
  int wide0  = 0;
  logic prev0 = 1'b0;
  logic [7:0] sent0 [$];

  uart_tx_fifo_if #(.DEPTH_LOG2(4)) if0 ();
  uart_tx_fifo_if #(.DEPTH_LOG2(4)) if5 ();

  assign if0.txSendComplete = model_done | man0_done;
  assign if5.txSendComplete = man5_done;

  uart_tx_fifo #(
    .DEPTH_LOG2 (4),
    .GAP_CLKS   (0)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if0)
  );

  uart_tx_fifo #(
    .DEPTH_LOG2 (4),
    .GAP_CLKS   (5)
  ) dut5 (
    .clock (clock),
    .reset (reset),
    .bus   (if5)
  );

  always @(negedge clock) begin
    if (if0.txSend) begin
      sends0 = sends0 + 1;
      sent0.push_back(if0.txIn);
    end
    if (if0.txSend && prev0)
      wide0 = wide0 + 1;
    prev0 = if0.txSend;
    if (if0.overflow)
      ovf0 = ovf0 + 1;
    if (if0.full)
      full0 = full0 + 1;
    if (if5.txSend)
      sends5 = sends5 + 1;
  end

  // Transmitter model: completes each byte tx_delay clocks after txSend.
  always begin
    @(negedge clock);
    if (auto0 && if0.txSend) begin
      repeat (tx_delay) @(posedge clock);
      #1 model_done = 1'b1;
      @(posedge clock);
      #1 model_done = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  int b;
  int qb;
  int ob;
  int fb;
  int b5;
  int lat;
  bit found;

  initial begin
    if0.wrData = '0;
    if0.wrEn   = 1'b0;
    if0.flush  = 1'b0;
    if5.wrData = '0;
    if5.wrEn   = 1'b0;
    if5.flush  = 1'b0;

    // reset state
    steps(3);
    chk("rst_empty", if0.empty, 1);
    chk("rst_full", if0.full, 0);
    chk("rst_count", if0.count, 0);
    chk("rst_ovf", if0.overflow, 0);
    chk("rst_send", if0.txSend, 0);
    chk("rst_txin", if0.txIn, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst5_empty", if5.empty, 1);
    chk("rst5_busy", if5.busy, 0);
    reset = 1'b0;
    step();

    // single byte
    b = sends0;
    if0.wrData = 8'hA5;
    if0.wrEn   = 1'b1;
    step();
    if0.wrEn   = 1'b0;
    chk("sb_cnt1", if0.count, 1);
    chk("sb_empty0", if0.empty, 0);
    chk("sb_nosend", if0.txSend, 0);
    chk("sb_busy", if0.busy, 1);
    step();
    chk("sb_send", if0.txSend, 1);
    chk("sb_txin", if0.txIn, 8'hA5);
    chk("sb_cnt0", if0.count, 0);
    chk("sb_empty1", if0.empty, 1);
    step();
    chk("sb_send_w", if0.txSend, 0);
    chk("sb_txin_h", if0.txIn, 8'hA5);
    steps(5);
    chk("sb_txin_h2", if0.txIn, 8'hA5);
    chk("sb_busy_w", if0.busy, 1);
    man0_done = 1'b1;
    step();
    man0_done = 1'b0;
    chk("sb_busy_drop", if0.busy, 0);
    steps(3);
    chk("sb_nsend", sends0 - b, 1);

    // burst of 16 plus a 17th after first pop
    b  = sends0;
    qb = sent0.size();
    fb = full0;
    ob = ovf0;
    tx_delay = 1390;
    auto0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if0.wrData = 8'(i);
      if0.wrEn   = 1'b1;
      step();
    end
    if0.wrEn = 1'b0;
    chk("bu_no_full", full0 - fb, 0);
    chk("bu_cnt15", if0.count, 15);
    if0.wrData = 8'h10;
    if0.wrEn   = 1'b1;
    step();
    if0.wrEn   = 1'b0;
    chk("bu_w17_cnt", if0.count, 16);
    chk("bu_w17_ovf", if0.overflow, 0);
    for (int k = 0; k < 30000; k++) begin
      if (sends0 - b == 17 && !if0.busy)
        break;
      step();
    end
    chk("bu_nsend", sends0 - b, 17);
    chk("bu_idle", if0.busy, 0);
    for (int i = 0; i < 17; i++)
      chk($sformatf("bu_b%0d", i), sent0[qb + i], i);
    chk("bu_ovf", ovf0 - ob, 0);
    auto0 = 1'b0;

    // overflow with a stalled transmitter
    b  = sends0;
    qb = sent0.size();
    ob = ovf0;
    for (int i = 0; i < 18; i++) begin
      if0.wrData = 8'(8'h20 + i);
      if0.wrEn   = 1'b1;
      step();
    end
    if0.wrEn = 1'b0;
    chk("of_cnt", if0.count, 16);
    chk("of_full", if0.full, 1);
    chk("of_pulse", if0.overflow, 1);
    chk("of_inflight", sends0 - b, 1);
    chk("of_txin", if0.txIn, 8'h20);
    step();
    chk("of_pulse_w", if0.overflow, 0);
    chk("of_npulse", ovf0 - ob, 1);
    tx_delay = 20;
    auto0 = 1'b1;
    man0_done = 1'b1;
    step();
    man0_done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (sends0 - b == 17 && !if0.busy)
        break;
      step();
    end
    chk("of_nsend", sends0 - b, 17);
    for (int i = 0; i < 17; i++)
      chk($sformatf("of_b%0d", i), sent0[qb + i], 8'h20 + i);
    steps(30);
    chk("of_no_b18", sends0 - b, 17);
    auto0 = 1'b0;

    // flush while WAIT_DONE with 4 queued
    b  = sends0;
    ob = ovf0;
    for (int i = 0; i < 5; i++) begin
      if0.wrData = 8'(8'h40 + i);
      if0.wrEn   = 1'b1;
      step();
    end
    if0.wrEn = 1'b0;
    chk("fl_cnt4", if0.count, 4);
    chk("fl_busy", if0.busy, 1);
    if0.flush  = 1'b1;
    if0.wrEn   = 1'b1;
    if0.wrData = 8'h55;
    step();
    if0.flush  = 1'b0;
    if0.wrEn   = 1'b0;
    chk("fl_cnt0", if0.count, 0);
    chk("fl_empty", if0.empty, 1);
    chk("fl_noovf", if0.overflow, 0);
    chk("fl_busy_h", if0.busy, 1);
    chk("fl_txin", if0.txIn, 8'h40);
    man0_done = 1'b1;
    step();
    man0_done = 1'b0;
    chk("fl_idle", if0.busy, 0);
    steps(10);
    chk("fl_nsend", sends0 - b, 1);
    chk("fl_novf", ovf0 - ob, 0);
    chk("fl_cnt_end", if0.count, 0);

    // inter-byte gap of 5 clocks
    b5 = sends5;
    if5.wrData = 8'h61;
    if5.wrEn   = 1'b1;
    step();
    if5.wrData = 8'h62;
    step();
    if5.wrEn   = 1'b0;
    chk("gp_send1", if5.txSend, 1);
    chk("gp_txin1", if5.txIn, 8'h61);
    chk("gp_cnt1", if5.count, 1);
    steps(4);
    man5_done = 1'b1;
    step();
    man5_done = 1'b0;
    chk("gp_busy", if5.busy, 1);
    lat   = 0;
    found = 1'b0;
    for (int j = 1; j <= 20 && !found; j++) begin
      step();
      if (if5.txSend) begin
        found = 1'b1;
        lat   = j;
      end
    end
    chk("gp_latency", lat, 6);
    chk("gp_txin2", if5.txIn, 8'h62);
    steps(2);
    man5_done = 1'b1;
    step();
    man5_done = 1'b0;
    steps(4);
    chk("gp_busy_hold", if5.busy, 1);
    step();
    chk("gp_idle", if5.busy, 0);
    chk("gp_nsend", sends5 - b5, 2);

    // reset mid-frame, then a stray complete
    b = sends0;
    for (int i = 0; i < 3; i++) begin
      if0.wrData = 8'(8'h71 + i);
      if0.wrEn   = 1'b1;
      step();
    end
    if0.wrEn = 1'b0;
    steps(3);
    chk("rm_busy", if0.busy, 1);
    chk("rm_cnt", if0.count, 2);
    reset = 1'b1;
    step();
    chk("rm_empty", if0.empty, 1);
    chk("rm_count", if0.count, 0);
    chk("rm_full", if0.full, 0);
    chk("rm_send", if0.txSend, 0);
    chk("rm_txin", if0.txIn, 0);
    chk("rm_busy0", if0.busy, 0);
    chk("rm_ovf", if0.overflow, 0);
    reset = 1'b0;
    step();
    man0_done = 1'b1;
    step();
    man0_done = 1'b0;
    steps(5);
    chk("rm_stray_send", if0.txSend, 0);
    chk("rm_stray_busy", if0.busy, 0);
    chk("rm_stray_empty", if0.empty, 1);
    chk("rm_nsend", sends0 - b, 1);

    chk("send_width", wide0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
